// File: rtl/ship_pkg.sv
// Shared definitions for the ship lock dispatcher: FSM state encoding,
// default handshake timeout and a small state-classification helper.
// Reused by the dispatcher RTL, the lock-side model and the tester.
package ship_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARRIVE,
        WAIT_DOCK,
        DEPART,
        WAIT_CLEAR,
        FAULT
    } ship_state_t;

    // States in which the handshake timeout is running.
    function automatic logic is_wait_state(ship_state_t s);
        return (s == ARRIVE) || (s == WAIT_DOCK) || (s == DEPART) || (s == WAIT_CLEAR);
    endfunction

endpackage

// File: rtl/ship_dispatch_if.sv
// Handshake bundle between the ship dispatcher and its environment.
//   requestIn/requestOut : one-cycle request pulses (ship at sea / ship in lock)
//   shipDocked/openDoor  : lock status level and door-open acknowledge
//   arriving/departing   : level requests to the lock
//   inCount/outCount     : pending entry / exit request counts (QW bits)
//   busy/overflow/fault  : FSM activity, sticky dropped-request, sticky timeout
// master: environment side; slave: dispatcher side.
interface ship_dispatch_if #(
    parameter int unsigned QW = 3
);
    logic          requestIn;
    logic          requestOut;
    logic          shipDocked;
    logic          openDoor;
    logic          arriving;
    logic          departing;
    logic [QW-1:0] inCount;
    logic [QW-1:0] outCount;
    logic          busy;
    logic          overflow;
    logic          fault;

    modport master (
        output requestIn, requestOut, shipDocked, openDoor,
        input  arriving, departing, inCount, outCount, busy, overflow, fault
    );

    modport slave (
        input  requestIn, requestOut, shipDocked, openDoor,
        output arriving, departing, inCount, outCount, busy, overflow, fault
    );
endinterface

// File: rtl/ship_dispatch_sat_counter.sv
// Saturating up/down request counter.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   inc, dec     : increment / decrement requests (same cycle cancels out)
//   count        : current value, never wraps in either direction
//   saturate     : high when an increment is being dropped at full scale
module sat_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         saturate
);

    assign saturate = inc && !dec && (count == '1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && !dec && (count != '1)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ship_dispatch.sv
// Ship lock dispatcher: queues entry/exit requests and sequences the
// door handshake with the lock, one ship at a time.
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : ship_dispatch_if slave (requests, lock status, lock requests,
//           queue counts, busy, sticky overflow and fault)
// Any wait state lasting TIMEOUT cycles latches FAULT until reset.
module ship_dispatch
    import ship_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned QW      = 3
) (
    input  logic           clock,
    input  logic           reset,
    ship_dispatch_if.slave bus
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    ship_state_t   state;
    ship_state_t   nxt;
    logic [TW-1:0] tcnt;
    logic          timed_out;
    logic          dec_in;
    logic          dec_out;
    logic          sat_in;
    logic          sat_out;
    logic [QW-1:0] in_count;
    logic [QW-1:0] out_count;
    logic          arriving_q;
    logic          departing_q;
    logic          busy_q;
    logic          overflow_q;
    logic          fault_q;

    // Door acknowledge only consumes a request when one is queued.
    assign dec_in    = (state == ARRIVE) && bus.openDoor && (in_count != '0);
    assign dec_out   = (state == DEPART) && bus.openDoor && (out_count != '0);
    assign timed_out = (tcnt == TW'(TIMEOUT - 1));

    sat_counter #(.W(QW)) u_in_cnt (
        .clock    (clock),
        .reset    (reset),
        .inc      (bus.requestIn),
        .dec      (dec_in),
        .count    (in_count),
        .saturate (sat_in)
    );

    sat_counter #(.W(QW)) u_out_cnt (
        .clock    (clock),
        .reset    (reset),
        .inc      (bus.requestOut),
        .dec      (dec_out),
        .count    (out_count),
        .saturate (sat_out)
    );

    // A real exit on the last allowed cycle wins over the timeout.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.shipDocked && (out_count != '0))       nxt = DEPART;
                else if (!bus.shipDocked && (in_count != '0))  nxt = ARRIVE;
            end
            ARRIVE: begin
                if (dec_in)         nxt = WAIT_DOCK;
                else if (timed_out) nxt = FAULT;
            end
            WAIT_DOCK: begin
                if (bus.shipDocked) nxt = IDLE;
                else if (timed_out) nxt = FAULT;
            end
            DEPART: begin
                if (dec_out)        nxt = WAIT_CLEAR;
                else if (timed_out) nxt = FAULT;
            end
            WAIT_CLEAR: begin
                if (!bus.shipDocked) nxt = IDLE;
                else if (timed_out)  nxt = FAULT;
            end
            FAULT:   nxt = FAULT;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            tcnt        <= '0;
            arriving_q  <= 1'b0;
            departing_q <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state <= nxt;
            if ((nxt != state) || !is_wait_state(state)) tcnt <= '0;
            else                                         tcnt <= tcnt + 1'b1;
            arriving_q  <= (nxt == ARRIVE);
            departing_q <= (nxt == DEPART);
            busy_q      <= is_wait_state(nxt);
            fault_q     <= (nxt == FAULT);
            if (sat_in || sat_out) overflow_q <= 1'b1;
        end
    end

    assign bus.arriving  = arriving_q;
    assign bus.departing = departing_q;
    assign bus.inCount   = in_count;
    assign bus.outCount  = out_count;
    assign bus.busy      = busy_q;
    assign bus.overflow  = overflow_q;
    assign bus.fault     = fault_q;

endmodule
